// File: rtl/frame_swap_ctrl_pkg.sv
// rtl/frame_swap_ctrl_pkg.sv - shared state encoding and helpers for frame_swap_ctrl
//
// Purpose: state encoding for the buffer-swap sequencer and a saturating
// increment helper used by the missed-frame counter.
// Ports: none (package).
package frame_swap_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_RENDER = 3'd1,
    S_WAIT   = 3'd2,
    S_SWAP   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  // Increment val unless it has already reached max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/frame_swap_ctrl_edge_sync.sv
// rtl/frame_swap_ctrl_edge_sync.sv - synchroniser with rising-edge pulse
//
// Purpose: brings an asynchronous level into clk and emits a one-cycle pulse
// per rising edge. s1/s2 form the metastability chain, s3 remembers the
// previous synchronised level.
// Ports:
//   clk     in   system clock
//   resetn  in   async active-low reset
//   din     in   asynchronous level
//   rise    out  one-cycle pulse per synchronised rising edge of din
module edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/frame_swap_ctrl.sv
// rtl/frame_swap_ctrl.sv - frame-tick driven double-buffer swap sequencer
//
// Purpose: consumer end of the divided frame clock. Synchronises frame_clk,
// turns its rising edges into frame ticks and sequences front/back buffer
// swaps between the VGA scanner and the renderer. With FRAME_SWAP_CLEAR_EN
// defined, the new back buffer is swept to BG_COLOR after every swap (and
// once after reset); otherwise the clear port is held idle.
// Ports:
//   clk           in   system clock
//   resetn        in   async active-low reset
//   frame_clk     in   divided frame clock, asynchronous to clk
//   draw_done     in   pulse: renderer finished the back buffer
//   render_start  out  pulse: renderer may start on the back buffer
//   front_sel     out  buffer scanned by VGA (back buffer = ~front_sel)
//   frame_tick    out  pulse per synchronised frame_clk rising edge
//   clr_we        out  clear-sweep write enable
//   clr_addr      out  clear-sweep address into the back buffer
//   clr_color     out  clear-sweep data (BG_COLOR)
//   busy          out  high except while waiting for a frame tick
//   overrun_cnt   out  saturating count of frame ticks that missed a swap
module frame_swap_ctrl
  import frame_swap_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = 15,
  parameter int                 NUM_PIX  = 19200,
  parameter int                 COLOR_W  = 3,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  parameter int                 OVR_W    = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_clk,
  input  logic               draw_done,
  output logic               render_start,
  output logic               front_sel,
  output logic               frame_tick,
  output logic               clr_we,
  output logic [ADDR_W-1:0]  clr_addr,
  output logic [COLOR_W-1:0] clr_color,
  output logic               busy,
  output logic [OVR_W-1:0]   overrun_cnt
);

`ifdef FRAME_SWAP_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  // Where the sequencer goes after reset and after each swap.
  localparam state_t             S_POST    = CLEAR_EN ? S_CLEAR : S_RENDER;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [OVR_W-1:0]   OVR_MAX   = {OVR_W{1'b1}};

  state_t state, state_nxt;
  logic   ovr_hit;
  logic   last_pix;

  edge_sync u_frame_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (frame_clk),
    .rise   (frame_tick)
  );

  assign last_pix = (clr_addr == LAST_ADDR);

  // A tick is only consumed in S_WAIT, or in S_RENDER when it coincides
  // with draw_done; everywhere else it is a missed frame.
  always_comb begin
    state_nxt = state;
    ovr_hit   = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = S_POST;
        ovr_hit   = frame_tick;
      end
      S_RENDER: begin
        if (draw_done) begin
          state_nxt = frame_tick ? S_SWAP : S_WAIT;
        end else begin
          ovr_hit = frame_tick;
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        state_nxt = S_POST;
        ovr_hit   = frame_tick;
      end
      S_CLEAR: begin
        ovr_hit = frame_tick;
        if (last_pix) begin
          state_nxt = S_RENDER;
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_INIT;
      front_sel    <= 1'b0;
      render_start <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      render_start <= (state_nxt == S_RENDER) && (state != S_RENDER);
      if ((state_nxt == S_SWAP) && (state != S_SWAP)) begin
        front_sel <= ~front_sel;
      end
      if (ovr_hit) begin
        overrun_cnt <= OVR_W'(sat_inc(32'(overrun_cnt), 32'(OVR_MAX)));
      end
    end
  end

  // Sweep address only advances inside S_CLEAR and is back at 0 as soon as
  // the sweep ends, so the next sweep always starts from pixel 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_addr <= '0;
    end else if ((state == S_CLEAR) && !last_pix) begin
      clr_addr <= clr_addr + ADDR_W'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  assign clr_we    = CLEAR_EN && (state == S_CLEAR);
  assign clr_color = BG_COLOR;
  assign busy      = (state != S_WAIT);

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb/tb_frame_swap_ctrl.sv - self-checking bench for frame_swap_ctrl
module tb_frame_swap_ctrl;

  localparam int NPIX    = 16;
  localparam int OVR_MAX = 3;

`ifdef FRAME_SWAP_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  // Reference model phases: booting, renderer drawing, holding for a tick,
  // flipping buffers, sweeping the back buffer.
  localparam int P_BOOT  = 0;
  localparam int P_DRAW  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_FLIP  = 3;
  localparam int P_SWEEP = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       fc = 1'b0;
  logic       dd = 1'b0;
  logic       render_start, front_sel, frame_tick, clr_we, busy;
  logic [3:0] clr_addr;
  logic [2:0] clr_color;
  logic [1:0] overrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase, m_idx, m_ovr;
  bit m_front, m_rs, m_tick;
  bit fc_seen[$];

  frame_swap_ctrl #(
    .ADDR_W   (4),
    .NUM_PIX  (NPIX),
    .COLOR_W  (3),
    .BG_COLOR (3'b000),
    .OVR_W    (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_clk    (fc),
    .draw_done    (dd),
    .render_start (render_start),
    .front_sel    (front_sel),
    .frame_tick   (frame_tick),
    .clr_we       (clr_we),
    .clr_addr     (clr_addr),
    .clr_color    (clr_color),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_phase = P_BOOT;
    m_idx   = 0;
    m_ovr   = 0;
    m_front = 1'b0;
    m_rs    = 1'b0;
    m_tick  = 1'b0;
    fc_seen = '{1'b0, 1'b0, 1'b0};
  endtask

  // One clock edge of the behavioural model, using the inputs held before the edge.
  task automatic model_edge();
    int nxt;
    bit tk;
    tk = m_tick;
    if (tk && (m_phase != P_HOLD) && !(m_phase == P_DRAW && dd))
      m_ovr = (m_ovr >= OVR_MAX) ? OVR_MAX : m_ovr + 1;
    case (m_phase)
      P_BOOT:  nxt = CLR_EN ? P_SWEEP : P_DRAW;
      P_SWEEP: nxt = (m_idx == NPIX - 1) ? P_DRAW : P_SWEEP;
      P_DRAW:  nxt = dd ? (tk ? P_FLIP : P_HOLD) : P_DRAW;
      P_HOLD:  nxt = tk ? P_FLIP : P_HOLD;
      default: nxt = CLR_EN ? P_SWEEP : P_DRAW;
    endcase
    m_idx = (m_phase == P_SWEEP && nxt == P_SWEEP) ? m_idx + 1 : 0;
    m_rs  = (nxt == P_DRAW) && (m_phase != P_DRAW);
    if (nxt == P_FLIP) m_front = !m_front;
    m_phase = nxt;
    // A rising edge of frame_clk shows up as a tick two samples later.
    fc_seen.push_front(fc);
    void'(fc_seen.pop_back());
    m_tick = fc_seen[1] & ~fc_seen[2];
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic sweep_to_render();
    int c;
    for (c = 1; c <= NPIX + 8; c++) begin
      dd = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if (clr_we !== (CLR_EN && m_phase == P_SWEEP)) $display("FAIL sweep_we: got %0b expected %0b", clr_we, (CLR_EN && m_phase == P_SWEEP));
      else n_pass++;
      n_checks++;
      if (clr_addr !== m_idx[3:0]) $display("FAIL sweep_addr: got %0d expected %0d", clr_addr, m_idx);
      else n_pass++;
      n_checks++;
      if (render_start !== m_rs) $display("FAIL sweep_render_start: got %0b expected %0b", render_start, m_rs);
      else n_pass++;
      if (render_start === 1'b1) break;
    end
    dd = 1'b0;
    n_checks++;
    if (render_start !== 1'b1) $display("FAIL sweep_end: got render_start %0b expected 1", render_start);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    dd = 1'b0;
    fc = 1'b0;
    model_reset();
    repeat (3) step();
    n_checks++;
    if (render_start !== 1'b0) $display("FAIL reset_render_start: got %0b expected 0", render_start); else n_pass++;
    n_checks++;
    if (front_sel !== 1'b0) $display("FAIL reset_front_sel: got %0b expected 0", front_sel); else n_pass++;
    n_checks++;
    if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick: got %0b expected 0", frame_tick); else n_pass++;
    n_checks++;
    if (clr_we !== 1'b0) $display("FAIL reset_clr_we: got %0b expected 0", clr_we); else n_pass++;
    n_checks++;
    if (clr_addr !== 4'd0) $display("FAIL reset_clr_addr: got %0d expected 0", clr_addr); else n_pass++;
    n_checks++;
    if (clr_color !== 3'b000) $display("FAIL reset_clr_color: got %0d expected 0", clr_color); else n_pass++;
    n_checks++;
    if (overrun_cnt !== 2'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); else n_pass++;
  endtask

  task automatic test_startup_sweep();
    int cyc;
    resetn = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      step();
      n_checks++;
      if (clr_we !== (CLR_EN && m_phase == P_SWEEP)) $display("FAIL start_we: got %0b expected %0b", clr_we, (CLR_EN && m_phase == P_SWEEP));
      else n_pass++;
      n_checks++;
      if (clr_addr !== m_idx[3:0]) $display("FAIL start_addr: got %0d expected %0d", clr_addr, m_idx);
      else n_pass++;
      if (render_start === 1'b1) break;
    end
    n_checks++;
    if (cyc !== (CLR_EN ? NPIX + 1 : 1)) $display("FAIL start_latency: got %0d expected %0d", cyc, (CLR_EN ? NPIX + 1 : 1));
    else n_pass++;
    n_checks++;
    if (front_sel !== 1'b0) $display("FAIL start_front_sel: got %0b expected 0", front_sel); else n_pass++;
    step();
    n_checks++;
    if (render_start !== m_rs) $display("FAIL start_pulse_width: got %0b expected %0b", render_start, m_rs); else n_pass++;
  endtask

  task automatic test_swap();
    bit f0;
    int lat;
    repeat ($urandom_range(0, 4)) step();
    dd = 1'b1;
    step();
    dd = 1'b0;
    n_checks++;
    if (busy !== (m_phase != P_HOLD)) $display("FAIL swap_wait_busy: got %0b expected %0b", busy, (m_phase != P_HOLD)); else n_pass++;
    dd = 1'b1;
    step();
    dd = 1'b0;
    repeat ($urandom_range(0, 3)) step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL swap_wait_hold: got busy %0b expected 0", busy); else n_pass++;
    f0 = m_front;
    lat = -1;
    fc = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++;
      if (frame_tick !== m_tick) $display("FAIL swap_tick: got %0b expected %0b", frame_tick, m_tick); else n_pass++;
      if (frame_tick === 1'b1 && lat < 0) lat = c;
      if (front_sel !== f0) break;
    end
    fc = 1'b0;
    n_checks++;
    if (lat < 1 || lat > 3) $display("FAIL swap_tick_latency: got %0d expected 1..3", lat); else n_pass++;
    n_checks++;
    if (front_sel !== m_front || front_sel !== !f0) $display("FAIL swap_front_sel: got %0b expected %0b", front_sel, !f0); else n_pass++;
    sweep_to_render();
  endtask

  task automatic test_overrun();
    bit f0;
    int ovr0;
    f0 = m_front;
    ovr0 = m_ovr;
    fc = 1'b1;
    repeat ($urandom_range(3, 5)) step();
    fc = 1'b0;
    repeat ($urandom_range(2, 4)) step();
    n_checks++;
    if (overrun_cnt !== m_ovr[1:0] || m_ovr != ovr0 + 1) $display("FAIL overrun_count: got %0d expected %0d", overrun_cnt, ovr0 + 1); else n_pass++;
    n_checks++;
    if (front_sel !== f0) $display("FAIL overrun_front_sel: got %0b expected %0b", front_sel, f0); else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL overrun_busy: got %0b expected 1", busy); else n_pass++;
    dd = 1'b1;
    step();
    dd = 1'b0;
    fc = 1'b1;
    repeat (3) step();
    fc = 1'b0;
    n_checks++;
    if (front_sel !== m_front || front_sel !== !f0) $display("FAIL overrun_next_swap: got %0b expected %0b", front_sel, !f0); else n_pass++;
    sweep_to_render();
  endtask

  task automatic test_same_cycle();
    bit f0;
    int ovr0;
    f0 = m_front;
    ovr0 = m_ovr;
    fc = 1'b1;
    for (int c = 0; c < 5 && !m_tick; c++) step();
    n_checks++;
    if (frame_tick !== 1'b1) $display("FAIL same_tick_present: got %0b expected 1", frame_tick); else n_pass++;
    dd = 1'b1;
    step();
    dd = 1'b0;
    fc = 1'b0;
    n_checks++;
    if (front_sel !== !f0 || front_sel !== m_front) $display("FAIL same_front_sel: got %0b expected %0b", front_sel, !f0); else n_pass++;
    n_checks++;
    if (overrun_cnt !== ovr0[1:0]) $display("FAIL same_overrun: got %0d expected %0d", overrun_cnt, ovr0); else n_pass++;
    sweep_to_render();
  endtask

  task automatic test_saturate();
    for (int t = 0; t < 5; t++) begin
      fc = 1'b1;
      repeat ($urandom_range(3, 5)) step();
      fc = 1'b0;
      repeat ($urandom_range(2, 4)) step();
      n_checks++;
      if (overrun_cnt !== m_ovr[1:0]) $display("FAIL sat_step: got %0d expected %0d", overrun_cnt, m_ovr); else n_pass++;
    end
    n_checks++;
    if (overrun_cnt !== 2'd3) $display("FAIL sat_final: got %0d expected 3", overrun_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    bit f0;
    f0 = m_front;
    dd = 1'b1;
    step();
    dd = 1'b0;
    fc = 1'b1;
    for (int c = 0; c < 8 && front_sel === f0; c++) step();
    fc = 1'b0;
    for (int c = 0; c < 12 && CLR_EN && m_idx != 7; c++) step();
    n_checks++;
    if (clr_addr !== m_idx[3:0]) $display("FAIL mid_addr_before: got %0d expected %0d", clr_addr, m_idx); else n_pass++;
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (clr_we !== 1'b0) $display("FAIL mid_clr_we: got %0b expected 0", clr_we); else n_pass++;
    n_checks++;
    if (clr_addr !== 4'd0) $display("FAIL mid_clr_addr: got %0d expected 0", clr_addr); else n_pass++;
    n_checks++;
    if (front_sel !== 1'b0) $display("FAIL mid_front_sel: got %0b expected 0", front_sel); else n_pass++;
    n_checks++;
    if (overrun_cnt !== 2'd0) $display("FAIL mid_overrun: got %0d expected 0", overrun_cnt); else n_pass++;
    step();
    test_startup_sweep();
  endtask

  initial begin
    test_reset();
    test_startup_sweep();
    test_swap();
    test_overrun();
    test_same_cycle();
    test_saturate();
    test_swap();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
